// File: rtl/key_transmitter.sv
// Public-key word streamer: grants one request from the key-send stage,
// captures (n, e) and streams them LS word first over a valid/ready port.
module key_transmitter #(
    parameter int KEY_WIDTH  = 128,
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  request,
    input  logic [KEY_WIDTH-1:0]  n,
    input  logic [KEY_WIDTH-1:0]  e,
    output logic                  accept,
    output logic [WORD_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  tx_sel,
    output logic                  tx_last,
    output logic                  busy,
    output logic                  done
);

    localparam int NUM_WORDS = KEY_WIDTH / WORD_WIDTH;
    localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        SETTLE,
        CAPTURE,
        SEND,
        DONE
    } state_t;

    state_t                 state;
    logic [KEY_WIDTH-1:0]   key_n;
    logic [KEY_WIDTH-1:0]   key_e;
    logic [IDX_W-1:0]       idx;
    logic                   armed;

    logic [IDX_W-1:0]       next_idx;
    logic                   next_sel;
    logic                   next_last;
    logic [WORD_WIDTH-1:0]  next_word;
    logic                   xfer;
    int                     base;

    // Next word is pre-computed so tx_data can be a register.
    always_comb begin
        xfer = tx_valid && tx_ready;
        if (idx == LAST_IDX) begin
            next_idx = '0;
            next_sel = 1'b1;
        end else begin
            next_idx = idx + 1'b1;
            next_sel = tx_sel;
        end
        next_last = next_sel && (next_idx == LAST_IDX);
        base      = int'(next_idx) * WORD_WIDTH;
        if (next_sel) begin
            next_word = key_e[base +: WORD_WIDTH];
        end else begin
            next_word = key_n[base +: WORD_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            key_n    <= '0;
            key_e    <= '0;
            idx      <= '0;
            armed    <= 1'b1;
            accept   <= 1'b0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            tx_sel   <= 1'b0;
            tx_last  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            accept <= 1'b0;
            done   <= 1'b0;

            // A level request must drop before it can be granted again.
            if (state == CAPTURE) begin
                armed <= 1'b0;
            end else if (!request) begin
                armed <= 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (request && armed) begin
                        state  <= GRANT;
                        accept <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                GRANT: begin
                    state <= SETTLE;
                end
                SETTLE: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    key_n    <= n;
                    key_e    <= e;
                    idx      <= '0;
                    tx_sel   <= 1'b0;
                    tx_last  <= 1'b0;
                    tx_data  <= n[WORD_WIDTH-1:0];
                    tx_valid <= 1'b1;
                    state    <= SEND;
                end
                SEND: begin
                    if (xfer) begin
                        if (tx_last) begin
                            state    <= DONE;
                            tx_valid <= 1'b0;
                            tx_last  <= 1'b0;
                            tx_sel   <= 1'b0;
                            tx_data  <= '0;
                            done     <= 1'b1;
                        end else begin
                            idx     <= next_idx;
                            tx_sel  <= next_sel;
                            tx_last <= next_last;
                            tx_data <= next_word;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_transmitter.sv
// Directed bench for key_transmitter: vector table for the basic transfer,
// hand sequences for stuck request, backpressure, reset and late changes.
module tb_key_transmitter;

    localparam logic [127:0] KEY_N = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    localparam logic [127:0] KEY_E = 128'd65537;

    logic         clk;
    logic         rst;
    logic         request;
    logic [127:0] n;
    logic [127:0] e;
    logic         accept;
    logic [31:0]  tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         tx_sel;
    logic         tx_last;
    logic         busy;
    logic         done;

    logic         req64;
    logic [63:0]  n64;
    logic [63:0]  e64;
    logic         acc64;
    logic [63:0]  data64;
    logic         val64;
    logic         rdy64;
    logic         sel64;
    logic         last64;
    logic         busy64;
    logic         done64;

    int n_vec = 0;
    int n_bad = 0;

    key_transmitter #(.KEY_WIDTH(128), .WORD_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .request(request), .n(n), .e(e),
        .accept(accept), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_sel(tx_sel), .tx_last(tx_last),
        .busy(busy), .done(done)
    );

    key_transmitter #(.KEY_WIDTH(64), .WORD_WIDTH(64)) dut64 (
        .clk(clk), .rst(rst), .request(req64), .n(n64), .e(e64),
        .accept(acc64), .tx_data(data64), .tx_valid(val64),
        .tx_ready(rdy64), .tx_sel(sel64), .tx_last(last64),
        .busy(busy64), .done(done64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          req;
        bit          rdy;
        logic [5:0]  ctl;   // {accept, valid, sel, last, busy, done}
        bit          cd;
        logic [31:0] data;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one full transfer, checking every word against (kn, ke).
    task automatic stream(input logic [127:0] kn, input logic [127:0] ke,
                          input bit bp, input bit late, input string tag);
        logic [31:0] w[8];
        int k = 0;
        int acc = 0;
        int dn = 0;
        int cyc = 0;
        bit started = 0;
        for (int i = 0; i < 4; i++) begin
            w[i]     = kn[i*32 +: 32];
            w[4 + i] = ke[i*32 +: 32];
        end
        tx_ready = 1'b1;
        while (dn == 0 && cyc < 200) begin
            tick();
            cyc++;
            if (accept) acc++;
            if (done) dn++;
            if (tx_valid) begin
                started = 1;
                if (late) begin
                    n = '1;
                    e = '1;
                end
                if (k < 8) begin
                    chk({tag, " data"}, tx_data, w[k]);
                    chk({tag, " sel"}, tx_sel, (k >= 4));
                    chk({tag, " last"}, tx_last, (k == 7));
                end else begin
                    chk({tag, " extra word"}, k, 8);
                end
            end else if (started && !done) begin
                chk({tag, " valid retracted"}, tx_valid, 1);
            end
            tx_ready = bp ? ((cyc % 3) == 0) : 1'b1;
            if (tx_valid && tx_ready) k++;
        end
        chk({tag, " done seen"}, dn, 1);
        chk({tag, " word count"}, k, 8);
        chk({tag, " accepts"}, acc, 1);
        tick();
        chk({tag, " post done/busy"}, {done, busy}, 2'b00);
    endtask

    initial begin
        int wc;
        int seen_done;
        rst      = 1'b1;
        request  = 1'b0;
        tx_ready = 1'b0;
        n        = KEY_N;
        e        = KEY_E;
        req64    = 1'b0;
        n64      = 64'hDEAD_BEEF_CAFE_F00D;
        e64      = 64'd3;
        rdy64    = 1'b1;

        vecs[0]  = '{1, 0, 0, 6'b000000, 1, 32'h0};
        vecs[1]  = '{1, 0, 0, 6'b000000, 1, 32'h0};
        vecs[2]  = '{0, 1, 1, 6'b100010, 0, 32'h0};
        vecs[3]  = '{0, 1, 1, 6'b000010, 0, 32'h0};
        vecs[4]  = '{0, 1, 1, 6'b000010, 0, 32'h0};
        vecs[5]  = '{0, 1, 1, 6'b010010, 1, 32'h4455_6677};
        vecs[6]  = '{0, 1, 1, 6'b010010, 1, 32'h0011_2233};
        vecs[7]  = '{0, 1, 1, 6'b010010, 1, 32'h89AB_CDEF};
        vecs[8]  = '{0, 1, 1, 6'b010010, 1, 32'h0123_4567};
        vecs[9]  = '{0, 1, 1, 6'b011010, 1, 32'h0001_0001};
        vecs[10] = '{0, 1, 1, 6'b011010, 1, 32'h0};
        vecs[11] = '{0, 1, 1, 6'b011010, 1, 32'h0};
        vecs[12] = '{0, 1, 1, 6'b011110, 1, 32'h0};
        vecs[13] = '{0, 1, 1, 6'b000011, 0, 32'h0};
        vecs[14] = '{0, 1, 1, 6'b000000, 0, 32'h0};

        for (int i = 0; i < 15; i++) begin
            rst      = vecs[i].rst;
            request  = vecs[i].req;
            tx_ready = vecs[i].rdy;
            tick();
            chk($sformatf("vec%0d ctl", i),
                {accept, tx_valid, tx_sel, tx_last, busy, done},
                vecs[i].ctl);
            if (vecs[i].cd) begin
                chk($sformatf("vec%0d data", i), tx_data, vecs[i].data);
            end
        end

        // Stuck-high request must not be granted again.
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("stuck accept", {accept, busy}, 2'b00);
        end
        request = 1'b0;
        tick();
        request = 1'b1;
        stream(KEY_N, KEY_E, 1'b1, 1'b0, "backpressure");

        // Late n/e change after capture must not leak into the stream.
        request = 1'b0;
        tick();
        request = 1'b1;
        stream(KEY_N, KEY_E, 1'b0, 1'b1, "late change");
        n = KEY_N;
        e = KEY_E;

        // Reset while the third n word is on the bus.
        request = 1'b0;
        tick();
        request  = 1'b1;
        tx_ready = 1'b1;
        wc = 0;
        while (!tx_valid && wc < 20) begin
            tick();
            wc++;
        end
        chk("mid reset reached send", tx_valid, 1);
        tick();
        tick();
        chk("mid reset 3rd word", tx_data, 32'h89AB_CDEF);
        rst = 1'b1;
        tick();
        chk("mid reset ctl", {tx_valid, busy, accept, done}, 4'b0000);
        rst = 1'b0;
        stream(KEY_N, KEY_E, 1'b0, 1'b0, "after reset");
        request = 1'b0;

        // Single-word variant.
        req64     = 1'b1;
        wc        = 0;
        seen_done = 0;
        for (int c = 0; c < 30 && seen_done == 0; c++) begin
            tick();
            if (val64) begin
                wc++;
                if (wc == 1) begin
                    chk("w64 n word", data64, 64'hDEAD_BEEF_CAFE_F00D);
                    chk("w64 n sel/last", {sel64, last64}, 2'b00);
                end else if (wc == 2) begin
                    chk("w64 e word", data64, 64'd3);
                    chk("w64 e sel/last", {sel64, last64}, 2'b11);
                end
            end
            if (done64) seen_done = 1;
        end
        chk("w64 word count", wc, 2);
        chk("w64 done seen", seen_done, 1);
        req64 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
